// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 32-bit bus.
// It adds a one-cycle turnaround between owners, a hold-limit preemption and a lock watchdog.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     bus_busy,
    output logic                     timeout
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        TURN
    } state_e;

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [CW-1:0]     hold_q, hold_d;
    logic [N_REQ-1:0]  mask_q, mask_d;
    logic              tout_q, tout_d;

    logic [N_REQ-1:0]  cand;
    logic [N_REQ-1:0]  owner_oh;
    logic [N_REQ-1:0]  mask_set;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     idx;
    logic              pick_vld;
    logic              rel;
    logic              pre;
    logic              wd;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(N_REQ - 1)) ? '0 : v + IW'(1);
    endfunction

    assign cand     = req & ~mask_q;
    assign owner_oh = N_REQ'(1) << owner_q;

    // First candidate at or after the round-robin pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = rr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_vld && cand[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    assign rel = !req[owner_q];
    assign wd  = (hold_q == CW'(TIMEOUT - 1));
    assign pre = (hold_q == CW'(MAX_HOLD - 1)) && !lock[owner_q]
               && |(cand & ~owner_oh);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        hold_d   = hold_q;
        tout_d   = 1'b0;
        mask_set = '0;
        unique case (state_q)
            OWNED: begin
                hold_d = (hold_q == CW'(TIMEOUT)) ? hold_q : hold_q + CW'(1);
                if (rel || pre || wd) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    hold_d  = '0;
                    rr_d    = wrap_inc(owner_q);
                    if (wd) begin
                        tout_d   = 1'b1;
                        mask_set = owner_oh;
                    end
                end
            end
            IDLE, TURN: begin
                gnt_d   = '0;
                state_d = IDLE;
                if (pick_vld) begin
                    state_d = OWNED;
                    gnt_d   = N_REQ'(1) << pick;
                    owner_d = pick;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // A mask bit survives only while its requester keeps req high.
    assign mask_d = (mask_q | mask_set) & req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            mask_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            mask_q  <= mask_d;
            tout_q  <= tout_d;
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign bus_busy = |gnt_q;
    assign timeout  = tout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected output changes are queued with their cycle,
// and a negedge monitor pops one entry per observed change.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout;

    bus_arbiter #(
        .N_REQ(4),
        .MAX_HOLD(16),
        .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .lock(lock),
        .gnt(gnt),
        .owner(owner),
        .bus_busy(bus_busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic       t;
        int         id;
    } ev_t;

    ev_t  sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   ev_id = 0;
    bit   mon_en = 1'b0;
    logic [7:0] prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_ev(input int at, input logic [3:0] g, input logic [1:0] o,
                          input logic b, input logic t);
        ev_t e;
        e.cyc = at;
        e.g   = g;
        e.o   = o;
        e.b   = b;
        e.t   = t;
        e.id  = ev_id;
        ev_id++;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: each change of the output tuple consumes one expectation.
    always @(negedge clk) begin
        logic [7:0] cur;
        ev_t e;
        cur = {gnt, owner, bus_busy, timeout};
        if (!mon_en) begin
            prev = cur;
        end else if (cur !== prev) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected change at cyc %0d: gnt=%b owner=%0d busy=%b timeout=%b",
                         cyc, gnt, owner, bus_busy, timeout);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.g !== gnt || e.o !== owner
                    || e.b !== bus_busy || e.t !== timeout) begin
                    n_err++;
                    $display("FAIL ev%0d: got cyc %0d gnt=%b owner=%0d busy=%b to=%b, expected cyc %0d gnt=%b owner=%0d busy=%b to=%b",
                             e.id, cyc, gnt, owner, bus_busy, timeout,
                             e.cyc, e.g, e.o, e.b, e.t);
                end
            end
            prev = cur;
        end
    end

    initial begin
        int c;
        rst_n = 1'b1;
        req   = '0;
        lock  = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy", 32'(bus_busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Single grant and release; owner stays 0 through TURN.
        c = cyc;
        req = 4'b0001;
        exp_ev(c + 1, 4'b0001, 2'd0, 1'b1, 1'b0);
        exp_ev(c + 4, 4'b0000, 2'd0, 1'b0, 1'b0);
        wait_cyc(c + 3);
        req = 4'b0000;
        wait_cyc(c + 8);

        // Full contention rotates 0,1,2,3,0 with MAX_HOLD slices.
        do_reset();
        c = cyc;
        req = 4'b1111;
        exp_ev(c + 1,  4'b0001, 2'd0, 1'b1, 1'b0);
        exp_ev(c + 17, 4'b0000, 2'd0, 1'b0, 1'b0);
        exp_ev(c + 18, 4'b0010, 2'd1, 1'b1, 1'b0);
        exp_ev(c + 34, 4'b0000, 2'd1, 1'b0, 1'b0);
        exp_ev(c + 35, 4'b0100, 2'd2, 1'b1, 1'b0);
        exp_ev(c + 51, 4'b0000, 2'd2, 1'b0, 1'b0);
        exp_ev(c + 52, 4'b1000, 2'd3, 1'b1, 1'b0);
        exp_ev(c + 68, 4'b0000, 2'd3, 1'b0, 1'b0);
        exp_ev(c + 69, 4'b0001, 2'd0, 1'b1, 1'b0);
        exp_ev(c + 73, 4'b0000, 2'd0, 1'b0, 1'b0);
        wait_cyc(c + 72);
        req = 4'b0000;
        wait_cyc(c + 76);

        // Asynchronous reset while master 2 owns the bus.
        c = cyc;
        req = 4'b0100;
        exp_ev(c + 1, 4'b0100, 2'd2, 1'b1, 1'b0);
        wait_cyc(c + 3);
        exp_ev(c + 4, 4'b0000, 2'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_busy", 32'(bus_busy), 32'h0);
        chk("async_owner", 32'(owner), 32'h0);
        @(negedge clk);
        req   = 4'b0110;
        rst_n = 1'b1;
        exp_ev(c + 5, 4'b0010, 2'd1, 1'b1, 1'b0);
        wait_cyc(c + 7);
        req = 4'b0000;
        exp_ev(c + 8, 4'b0000, 2'd1, 1'b0, 1'b0);
        wait_cyc(c + 11);

        // Owner 2 releases as req[3] rises; pointer then moves 3 -> 0.
        c = cyc;
        req = 4'b0100;
        exp_ev(c + 1,  4'b0100, 2'd2, 1'b1, 1'b0);
        exp_ev(c + 4,  4'b0000, 2'd2, 1'b0, 1'b0);
        exp_ev(c + 5,  4'b1000, 2'd3, 1'b1, 1'b0);
        exp_ev(c + 9,  4'b0000, 2'd3, 1'b0, 1'b0);
        exp_ev(c + 12, 4'b0001, 2'd0, 1'b1, 1'b0);
        exp_ev(c + 15, 4'b0000, 2'd0, 1'b0, 1'b0);
        wait_cyc(c + 3);
        req = 4'b1000;
        wait_cyc(c + 8);
        req = 4'b0000;
        wait_cyc(c + 11);
        req = 4'b1111;
        wait_cyc(c + 14);
        req = 4'b0000;
        wait_cyc(c + 18);

        // Locked owner 0 is cut off by the watchdog and masked.
        do_reset();
        c = cyc;
        req  = 4'b0011;
        lock = 4'b0001;
        exp_ev(c + 1,  4'b0001, 2'd0, 1'b1, 1'b0);
        exp_ev(c + 65, 4'b0000, 2'd0, 1'b0, 1'b1);
        exp_ev(c + 66, 4'b0010, 2'd1, 1'b1, 1'b0);
        exp_ev(c + 71, 4'b0000, 2'd1, 1'b0, 1'b0);
        exp_ev(c + 79, 4'b0001, 2'd0, 1'b1, 1'b0);
        exp_ev(c + 83, 4'b0000, 2'd0, 1'b0, 1'b0);
        wait_cyc(c + 70);
        req = 4'b0001;
        wait_cyc(c + 76);
        req = 4'b0000;
        wait_cyc(c + 78);
        req  = 4'b0001;
        lock = 4'b0000;
        wait_cyc(c + 82);
        req = 4'b0000;
        wait_cyc(c + 86);

        // Lone unlocked requester: no preemption, watchdog still fires.
        c = cyc;
        req = 4'b0001;
        exp_ev(c + 1,  4'b0001, 2'd0, 1'b1, 1'b0);
        exp_ev(c + 65, 4'b0000, 2'd0, 1'b0, 1'b1);
        exp_ev(c + 66, 4'b0000, 2'd0, 1'b0, 1'b0);
        exp_ev(c + 73, 4'b0001, 2'd0, 1'b1, 1'b0);
        exp_ev(c + 76, 4'b0000, 2'd0, 1'b0, 1'b0);
        wait_cyc(c + 70);
        req = 4'b0000;
        wait_cyc(c + 72);
        req = 4'b0001;
        wait_cyc(c + 75);
        req = 4'b0000;
        wait_cyc(c + 82);

        while (sb.size() != 0) begin
            ev_t e;
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL ev%0d: never observed, expected cyc %0d gnt=%b owner=%0d",
                     e.id, e.cyc, e.g, e.o);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared 32-bit processor bus. It grants bus ownership to one of several bus masters at a time, such as the control unit, a debug loader and a DMA engine. It inserts a dead turnaround cycle between owners so two drivers never overlap on the tri-state bus. It enforces a fair hold limit, and a lock watchdog that can force a stuck master off the bus.

## Interface
- N_REQ, 4, number of requesters (2..8)
- MAX_HOLD, 16, owned cycles after which an unlocked owner is preempted if another request is pending (≥2)
- TIMEOUT, 64, owned cycles after which any owner, locked or not, is forcibly released (> MAX_HOLD)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-master bus request, level, held for the whole transfer
- lock  input  N_REQ  per-master lock; only the current owner's bit is used
- gnt  output  N_REQ  one-hot grant, registered; all zero when no owner
- owner  output  $clog2(N_REQ)  index of current or most recent owner
- bus_busy  output  1  high while any gnt bit is high
- timeout  output  1  one-cycle pulse when the watchdog forces a release

## Operation
- Reset values: gnt=0, owner=0, bus_busy=0, timeout=0, rr_ptr=0 (requester 0 highest priority), hold_cnt=0, mask=0, state IDLE.
- State IDLE (no grant):
  - Candidate set = req & ~mask.
  - If the set is non-empty, pick the first set bit scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Go to OWNED with gnt[winner]=1, owner=winner, hold_cnt=0.
- State OWNED:
  - hold_cnt increments each cycle and saturates at TIMEOUT.
  - Leave to TURN when any of these holds:
    - (a) req[owner]=0 (normal release);
    - (b) hold_cnt==MAX_HOLD-1, lock[owner]=0, and another unmasked request is pending (preemption);
    - (c) hold_cnt==TIMEOUT-1 (watchdog).
  - On exit: gnt goes to 0 and rr_ptr=(owner+1) mod N_REQ.
- State TURN:
  - Exactly one cycle with gnt=0, for bus turnaround.
  - Then go to IDLE, which re-arbitrates on the same edge. TURN→OWNED is direct if any candidate is pending.
- Watchdog exit (c):
  - Pulse timeout high for one cycle, coincident with the TURN cycle.
  - Set mask[owner]=1.
  - A masked requester is excluded from arbitration until it deasserts its req. mask bit i clears on any edge where req[i]=0.
- Preemption (b) does not mask the preempted master. It re-enters arbitration at lowest priority because of rr_ptr advance.
- lock is ignored for requesters that do not own the bus.
- owner holds its last value in TURN and IDLE.
- Simultaneous requests are resolved by round-robin order only.
- A req that rises in the same cycle as another master's release waits for the TURN cycle like any other requester.

## Timing
- Grant latency from idle: req[i] sampled high at edge k → gnt[i]=1 after edge k (visible in cycle k+1).
- Release: req[owner] sampled low at edge k → gnt=0 after edge k (TURN cycle). The next gnt is high after edge k+1 at the earliest.
- Minimum gap between two owners: exactly one cycle with gnt=0.
- Preemption: an owner granted after edge g loses gnt after edge g+MAX_HOLD. It owns exactly MAX_HOLD cycles.
- Watchdog: an owner granted after edge g loses gnt after edge g+TIMEOUT. timeout is high for cycle g+TIMEOUT+1 only.
- Asynchronous reset mid-transfer: gnt, bus_busy and timeout drop immediately without waiting for a clock edge. All state returns to reset values. The first grant after rst_n rises follows the IDLE rule.
- bus_busy equals |gnt, driven from registers, with no combinational path from req.

## Test plan
- Reset, then req=0001 → gnt=0001 one cycle later. Drop req → one gnt=0 cycle, bus_busy=0, owner stays 0.
- req=1111 held constantly, lock=0, MAX_HOLD=16 → grants rotate 0,1,2,3,0. Each owner gets 16 cycles, separated by one idle cycle.
- req=0011, lock[0]=1 → master 0 keeps the bus past MAX_HOLD. It is released at TIMEOUT=64 with a 1-cycle timeout pulse. Master 1 is granted on the next cycle. Master 0 is not re-granted until its req drops and rises again.
- Owner 2 drops req in the same cycle req[3] rises → TURN cycle, then gnt=1000. rr_ptr advances to 3, then 0.
- Assert rst_n=0 mid-transfer while gnt=0100 → gnt=0000 immediately. After release with req=0110, gnt=0010 (rr_ptr reset to 0).
- Single requester req=0001 held, lock=0 → no preemption at MAX_HOLD. The watchdog still fires at 64 cycles, and master 0 is masked until req drops.
